// File: rtl/pr_bus_pkg.sv
// rtl/pr_bus_pkg.sv - shared types and constants for the peripheral-bus arbiter
package pr_bus_pkg;

    localparam int PR_ADDR_W = 30;

    localparam logic [27:0] TIMER0_TAG = 28'h00007F0;
    localparam logic [27:0] TIMER1_TAG = 28'h00007F1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } pr_state_e;

    // Word address bits [29:2] are byte address bits [31:4].
    function automatic logic pr_no_device(input logic [PR_ADDR_W-1:0] addr);
        return (addr[PR_ADDR_W-1:2] != TIMER0_TAG) && (addr[PR_ADDR_W-1:2] != TIMER1_TAG);
    endfunction

endpackage

// File: rtl/pr_rr_pick.sv
// rtl/pr_rr_pick.sv - combinational two-way round-robin pick
module pr_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    // On a tie the master that did not win last time is chosen.
    assign gnt_valid = req0 | req1;
    assign gnt_id    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/pr_bus_arbiter.sv
// rtl/pr_bus_arbiter.sv - two-master req/ack arbiter in front of the Pr* bridge port
module pr_bus_arbiter
    import pr_bus_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [PR_ADDR_W-1:0] m0_addr,
    input  logic [31:0]          m0_wd,
    output logic                 m0_ack,
    output logic [31:0]          m0_rd,
    output logic                 m0_err,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [PR_ADDR_W-1:0] m1_addr,
    input  logic [31:0]          m1_wd,
    output logic                 m1_ack,
    output logic [31:0]          m1_rd,
    output logic                 m1_err,
    output logic [PR_ADDR_W-1:0] PrAddr,
    output logic                 PrWE,
    output logic [31:0]          PrWD,
    input  logic [31:0]          PrRD,
    output logic                 busy,
    output logic                 grant_id
);

    pr_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 gid_q, gid_d;
    logic                 busy_q, busy_d;
    logic                 lat_we_q, lat_we_d;
    logic [PR_ADDR_W-1:0] pr_addr_q, pr_addr_d;
    logic [31:0]          pr_wd_q, pr_wd_d;
    logic                 pr_we_q, pr_we_d;
    logic                 ack0_q, ack0_d, ack1_q, ack1_d;
    logic                 err0_q, err0_d, err1_q, err1_d;
    logic [31:0]          rd0_q, rd0_d, rd1_q, rd1_d;

    logic        gnt_valid, gnt_id;
    logic        dec_err;
    logic [31:0] rd_val;

    pr_rr_pick u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // pr_addr_q doubles as the latched address while in ACCESS.
    assign dec_err = pr_no_device(pr_addr_q);
    assign rd_val  = (dec_err | lat_we_q) ? 32'h0 : PrRD;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gid_d     = gid_q;
        busy_d    = busy_q;
        lat_we_d  = lat_we_q;
        pr_addr_d = pr_addr_q;
        pr_wd_d   = pr_wd_q;
        pr_we_d   = pr_we_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d   = ST_ACCESS;
                    gid_d     = gnt_id;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(ACCESS_CYCLES - 1);
                    lat_we_d  = gnt_id ? m1_we   : m0_we;
                    pr_we_d   = gnt_id ? m1_we   : m0_we;
                    pr_addr_d = gnt_id ? m1_addr : m0_addr;
                    pr_wd_d   = gnt_id ? m1_wd   : m0_wd;
                end
            end
            ST_ACCESS: begin
                // Single write strobe: only the first ACCESS cycle carries PrWE.
                pr_we_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    pr_addr_d = '0;
                    pr_wd_d   = '0;
                    ack0_d    = ~gid_q;
                    ack1_d    = gid_q;
                    err0_d    = ~gid_q & dec_err;
                    err1_d    = gid_q & dec_err;
                    rd0_d     = gid_q ? 32'h0 : rd_val;
                    rd1_d     = gid_q ? rd_val : 32'h0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = gid_q;
                busy_d  = 1'b0;
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                rd0_d   = 32'h0;
                rd1_d   = 32'h0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            gid_q     <= 1'b0;
            busy_q    <= 1'b0;
            lat_we_q  <= 1'b0;
            pr_addr_q <= '0;
            pr_wd_q   <= '0;
            pr_we_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gid_q     <= gid_d;
            busy_q    <= busy_d;
            lat_we_q  <= lat_we_d;
            pr_addr_q <= pr_addr_d;
            pr_wd_q   <= pr_wd_d;
            pr_we_q   <= pr_we_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign m0_ack   = ack0_q;
    assign m0_rd    = rd0_q;
    assign m0_err   = err0_q;
    assign m1_ack   = ack1_q;
    assign m1_rd    = rd1_q;
    assign m1_err   = err1_q;
    assign PrAddr   = pr_addr_q;
    assign PrWE     = pr_we_q;
    assign PrWD     = pr_wd_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb/tb_pr_bus_arbiter.sv - directed self-checking bench for pr_bus_arbiter
module tb_pr_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_we, m1_we;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd, PrRD;

    // a_* drives the ACCESS_CYCLES=1 instance, b_* the ACCESS_CYCLES=3 instance
    logic        a_m0_req, a_m1_req, b_m0_req, b_m1_req;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_PrWE, a_busy, a_gid;
    logic [31:0] a_m0_rd, a_m1_rd, a_PrWD;
    logic [29:0] a_PrAddr;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_PrWE, b_busy, b_gid;
    logic [31:0] b_m0_rd, b_m1_rd, b_PrWD;
    logic [29:0] b_PrAddr;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_ack;
    int exp_m;

    always #5 clk = ~clk;

    pr_bus_arbiter #(.ACCESS_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(a_m0_ack), .m0_rd(a_m0_rd), .m0_err(a_m0_err),
        .m1_req(a_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(a_m1_ack), .m1_rd(a_m1_rd), .m1_err(a_m1_err),
        .PrAddr(a_PrAddr), .PrWE(a_PrWE), .PrWD(a_PrWD), .PrRD(PrRD),
        .busy(a_busy), .grant_id(a_gid)
    );

    pr_bus_arbiter #(.ACCESS_CYCLES(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(b_m0_ack), .m0_rd(b_m0_rd), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(b_m1_ack), .m1_rd(b_m1_rd), .m1_err(b_m1_err),
        .PrAddr(b_PrAddr), .PrWE(b_PrWE), .PrWD(b_PrWD), .PrRD(PrRD),
        .busy(b_busy), .grant_id(b_gid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        {a_m0_req, a_m1_req, b_m0_req, b_m1_req} = '0;
        {m0_we, m1_we} = '0;
        m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0; PrRD = '0;
        tick(); tick();
        chk("rst_busy",   a_busy,   0);
        chk("rst_praddr", a_PrAddr, 0);
        chk("rst_prwe",   a_PrWE,   0);
        chk("rst_gid",    a_gid,    0);
        chk("rst_ack",    {b_m0_ack, b_m1_ack}, 0);
        reset = 1'b1;
        tick();

        // AC=1 write to Timer0
        m0_we = 1'b1; m0_addr = 30'h1FC1; m0_wd = 32'h0000_00FF; a_m0_req = 1'b1;
        tick();
        chk("w1_prwe",   a_PrWE,   1);
        chk("w1_praddr", a_PrAddr, 32'h1FC1);
        chk("w1_prwd",   a_PrWD,   32'hFF);
        chk("w1_gid",    a_gid,    0);
        m0_addr = 30'h0; m0_we = 1'b0;
        tick();
        chk("w1_ack",    a_m0_ack, 1);
        chk("w1_err",    a_m0_err, 0);
        chk("w1_prwe_end", a_PrWE, 0);
        chk("w1_m1ack",  a_m1_ack, 0);
        a_m0_req = 1'b0;
        tick();
        chk("w1_ack_off", a_m0_ack, 0);
        tick();
        chk("w1_nodup", a_busy, 0);

        // fresh reset so M0 wins the first tie, then alternate
        reset = 1'b0; tick(); reset = 1'b1; tick();
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 30'h1FC0; m1_addr = 30'h1FC4;
        PrRD = 32'h1234_5678;
        a_m0_req = 1'b1; a_m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_m = k % 2;
            tick();
            chk("rr_gid", a_gid, exp_m);
            tick();
            chk("rr_ack", {a_m1_ack, a_m0_ack}, (exp_m == 1) ? 2'b10 : 2'b01);
            chk("rr_rd", (exp_m == 1) ? a_m1_rd : a_m0_rd, 32'h1234_5678);
            if (k > 0) chk("rr_spacing", cyc - last_ack, 3);
            last_ack = cyc;
            if (exp_m == 1) a_m1_req = 1'b0; else a_m0_req = 1'b0;
            tick();
            if (k < 2) begin
                if (exp_m == 1) a_m1_req = 1'b1; else a_m0_req = 1'b1;
            end
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;

        // AC=3 M1 read of Timer1
        m1_we = 1'b0; m1_addr = 30'h1FC5; PrRD = 32'hDEAD_BEEF; b_m1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r3_praddr", b_PrAddr, 32'h1FC5);
            chk("r3_prwe",   b_PrWE,   0);
            chk("r3_noack",  b_m1_ack, 0);
        end
        tick();
        chk("r3_ack",   b_m1_ack, 1);
        chk("r3_rd",    b_m1_rd,  32'hDEAD_BEEF);
        chk("r3_err",   b_m1_err, 0);
        chk("r3_m0ack", b_m0_ack, 0);
        b_m1_req = 1'b0;
        tick();

        // unmapped address
        m0_we = 1'b0; m0_addr = 30'h0000_0C00; b_m0_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bad_prwe", b_PrWE, 0);
        end
        tick();
        chk("bad_ack", b_m0_ack, 1);
        chk("bad_err", b_m0_err, 1);
        chk("bad_rd",  b_m0_rd,  0);
        b_m0_req = 1'b0;
        tick();

        // reset in the second ACCESS cycle of an M1 write
        m1_we = 1'b1; m1_addr = 30'h1FC4; m1_wd = 32'hA5A5_0001; b_m1_req = 1'b1;
        tick();
        chk("rw_prwe", b_PrWE, 1);
        tick();
        reset = 1'b0;
        b_m1_req = 1'b0;
        tick();
        chk("rw_praddr", b_PrAddr, 0);
        chk("rw_prwd",   b_PrWD,   0);
        chk("rw_prwe0",  b_PrWE,   0);
        chk("rw_busy",   b_busy,   0);
        reset = 1'b1;
        tick();
        chk("rw_noack", b_m1_ack, 0);
        tick();
        chk("rw_noack2", b_m1_ack, 0);
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 30'h1FC0;
        b_m0_req = 1'b1; b_m1_req = 1'b1;
        tick();
        chk("rw_tie_gid", b_gid, 0);
        b_m1_req = 1'b0;
        tick(); tick(); tick();
        chk("rw_tie_ack", b_m0_ack, 1);
        b_m0_req = 1'b0;
        tick();

        // M1 request arrives during M0's DONE cycle
        b_m0_req = 1'b1;
        tick(); tick(); tick(); tick();
        chk("hs_m0ack", b_m0_ack, 1);
        b_m1_req = 1'b1;
        b_m0_req = 1'b0;
        tick();
        chk("hs_idle", b_busy, 0);
        tick();
        chk("hs_busy", b_busy, 1);
        chk("hs_gid",  b_gid,  1);
        tick(); tick(); tick();
        chk("hs_m1ack", {b_m1_ack, b_m0_ack}, 2'b10);
        b_m1_req = 1'b0;
        tick();
        chk("hs_end", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
